// File: rtl/clkdiv_prog.sv
// Programmable integer clock divider: registered, glitch-free Y with ceil(N/2) high cycles per N.
// Ratio updates and start/stop take effect only at period boundaries; DIV_ACK marks a newly applied ratio.
module clkdiv_prog #(
  parameter int WIDTH   = 8,
  parameter int RST_DIV = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [WIDTH-1:0] DIV,
  input  logic             DIV_VLD,
  output logic             Y,
  output logic             ACTIVE,
  output logic             DIV_ACK
);

  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO   = WIDTH'(2);
  localparam logic [WIDTH-1:0] RST_N = WIDTH'(RST_DIV);

  typedef enum logic {IDLE, RUN} mode_t;

  mode_t            mode;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] n;
  logic [WIDTH-1:0] p;
  logic             pf;

  logic [WIDTH-1:0] nreq;
  logic [WIDTH:0]   h;
  logic [WIDTH:0]   cnt_inc;
  logic             wrap;

  // One extra bit on h and cnt_inc keeps N = 2^WIDTH-1 from overflowing.
  always_comb begin
    nreq    = (DIV < TWO) ? TWO : DIV;
    h       = ({1'b0, n} + {{WIDTH{1'b0}}, 1'b1}) >> 1;
    cnt_inc = {1'b0, cnt} + {{WIDTH{1'b0}}, 1'b1};
    wrap    = (cnt == (n - ONE));
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      mode    <= IDLE;
      cnt     <= '0;
      n       <= RST_N;
      p       <= RST_N;
      pf      <= 1'b0;
      Y       <= 1'b0;
      ACTIVE  <= 1'b0;
      DIV_ACK <= 1'b0;
    end else begin
      DIV_ACK <= 1'b0;
      case (mode)
        IDLE: begin
          if (DIV_VLD) begin
            n       <= nreq;
            DIV_ACK <= 1'b1;
          end
          if (EN) begin
            mode   <= RUN;
            ACTIVE <= 1'b1;
            cnt    <= '0;
            Y      <= 1'b1;
          end
        end
        RUN: begin
          if (!wrap) begin
            cnt <= cnt_inc[WIDTH-1:0];
            Y   <= (cnt_inc < h);
            if (DIV_VLD) begin
              p  <= nreq;
              pf <= 1'b1;
            end
          end else begin
            cnt <= '0;
            // A strobe on the wrap edge itself supersedes any pending ratio.
            if (DIV_VLD) begin
              n       <= nreq;
              pf      <= 1'b0;
              DIV_ACK <= 1'b1;
            end else if (pf) begin
              n       <= p;
              pf      <= 1'b0;
              DIV_ACK <= 1'b1;
            end
            if (EN) begin
              Y <= 1'b1;
            end else begin
              mode   <= IDLE;
              ACTIVE <= 1'b0;
              Y      <= 1'b0;
            end
          end
        end
        default: begin
          mode   <= IDLE;
          ACTIVE <= 1'b0;
          Y      <= 1'b0;
          cnt    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clkdiv_prog.sv
// Bench for clkdiv_prog: directed scenarios then random traffic, checked against a period-position model.
module tb_clkdiv_prog;

  localparam int WIDTH   = 8;
  localparam int RST_DIV = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [WIDTH-1:0] div;
  logic             div_vld;
  logic             y;
  logic             active;
  logic             div_ack;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: running flag, position within the current period, ratio in force, pending ratio (-1 = none).
  bit m_run;
  int m_k;
  int m_n;
  int m_pend;
  bit m_ack;

  always #5 clk = ~clk;

  clkdiv_prog #(.WIDTH(WIDTH), .RST_DIV(RST_DIV)) dut (
    .CLK     (clk),
    .RST     (rst),
    .EN      (en),
    .DIV     (div),
    .DIV_VLD (div_vld),
    .Y       (y),
    .ACTIVE  (active),
    .DIV_ACK (div_ack)
  );

  task automatic model_step(input bit r, input bit e, input bit v, input int d);
    int req;
    req = (d < 2) ? 2 : d;
    if (r) begin
      m_run = 1'b0; m_k = 0; m_n = RST_DIV; m_pend = -1; m_ack = 1'b0;
      return;
    end
    m_ack = 1'b0;
    if (!m_run) begin
      if (v) begin m_n = req; m_ack = 1'b1; end
      if (e) begin m_run = 1'b1; m_k = 0; end
    end else if (m_k < m_n - 1) begin
      m_k++;
      if (v) m_pend = req;
    end else begin
      if (v) begin m_n = req; m_pend = -1; m_ack = 1'b1; end
      else if (m_pend >= 0) begin m_n = m_pend; m_pend = -1; m_ack = 1'b1; end
      m_k = 0;
      if (!e) m_run = 1'b0;
    end
  endtask

  task automatic check(input string tag);
    bit exp_y;
    exp_y = m_run && (m_k < (m_n + 1) / 2);
    n_assert++;
    assert (y === exp_y) else begin
      n_fail++;
      $error("FAIL %s y: observed %b expected %b at %0t", tag, y, exp_y, $time);
    end
    n_assert++;
    assert (active === m_run) else begin
      n_fail++;
      $error("FAIL %s active: observed %b expected %b at %0t", tag, active, m_run, $time);
    end
    n_assert++;
    assert (div_ack === m_ack) else begin
      n_fail++;
      $error("FAIL %s div_ack: observed %b expected %b at %0t", tag, div_ack, m_ack, $time);
    end
  endtask

  task automatic tick(input string tag, input bit r, input bit e, input bit v, input int d);
    @(negedge clk);
    rst = r; en = e; div_vld = v; div = WIDTH'(d);
    @(posedge clk);
    model_step(r, e, v, d);
    #1;
    check(tag);
  endtask

  task automatic run(input string tag, input int cycles, input bit e);
    for (int i = 0; i < cycles; i++) tick(tag, 1'b0, e, 1'b0, 0);
  endtask

  // Advance until the next edge is a wrap edge of a running period.
  task automatic to_wrap(input string tag);
    int guard;
    guard = 0;
    while (m_run && m_k != m_n - 1 && guard < 300) begin
      tick(tag, 1'b0, 1'b1, 1'b0, 0);
      guard++;
    end
    n_assert++;
    assert (guard < 300) else begin
      n_fail++;
      $error("FAIL %s to_wrap: observed %0d cycles required < 300", tag, guard);
    end
  endtask

  initial begin
    int hi, lo, acks;
    rst = 1'b1; en = 1'b0; div = '0; div_vld = 1'b0;

    // Reset, then free-run at the reset ratio of 2.
    for (int i = 0; i < 3; i++) tick("reset", 1'b1, 1'b0, 1'b0, 0);
    run("n2_run", 4, 1'b1);
    run("n2_stop", 2, 1'b0);

    // Program 5 in IDLE, start, two full periods.
    tick("idle_div5", 1'b0, 1'b0, 1'b1, 5);
    run("n5_run", 10, 1'b1);

    // Switch to 4 on a wrap, then two strobes mid-period: only the last (3) lands, once.
    to_wrap("to_n4");
    tick("set_n4", 1'b0, 1'b1, 1'b1, 4);
    run("n4_c0", 1, 1'b1);
    acks = 0;
    tick("strobe6", 1'b0, 1'b1, 1'b1, 6);
    acks += int'(div_ack);
    tick("strobe3", 1'b0, 1'b1, 1'b1, 3);
    acks += int'(div_ack);
    for (int i = 0; i < 5; i++) begin
      tick("n3_run", 1'b0, 1'b1, 1'b0, 0);
      acks += int'(div_ack);
    end
    n_assert++;
    assert (acks == 1) else begin
      n_fail++;
      $error("FAIL ack_count: observed %0d required 1", acks);
    end

    // Back to 4, then drop EN at cnt=0: the period completes and the divider parks.
    to_wrap("to_n4b");
    tick("set_n4b", 1'b0, 1'b1, 1'b1, 4);
    run("stop_mid", 6, 1'b0);
    tick("restart", 1'b0, 1'b1, 1'b0, 0);

    // Clamped ratios 0 and 1, each applied at a wrap.
    to_wrap("to_d0");
    tick("div0", 1'b0, 1'b1, 1'b1, 0);
    run("d0_run", 4, 1'b1);
    to_wrap("to_d1");
    tick("div1", 1'b0, 1'b1, 1'b1, 1);
    run("d1_run", 4, 1'b1);

    // Largest ratio: one full period must be 128 high / 127 low.
    to_wrap("to_d255");
    tick("div255", 1'b0, 1'b1, 1'b1, 255);
    hi = int'(y); lo = int'(!y);
    for (int i = 0; i < 254; i++) begin
      tick("d255_run", 1'b0, 1'b1, 1'b0, 0);
      if (y) hi++; else lo++;
    end
    n_assert++;
    assert (hi == 128 && lo == 127) else begin
      n_fail++;
      $error("FAIL d255_shape: observed %0d high %0d low required 128 high 127 low", hi, lo);
    end
    tick("d255_wrap", 1'b0, 1'b1, 1'b0, 0);

    // Reset at N=6, cnt=1 with a ratio pending: nothing survives.
    to_wrap("to_n6");
    tick("set_n6", 1'b0, 1'b1, 1'b1, 6);
    tick("pend9", 1'b0, 1'b1, 1'b1, 9);
    tick("mid_rst", 1'b1, 1'b1, 1'b0, 0);
    run("post_rst", 4, 1'b0);
    run("post_rst_run", 6, 1'b1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      bit r, e, v;
      int d;
      r = ($urandom_range(0, 299) == 0);
      e = ($urandom_range(0, 9) != 0);
      v = ($urandom_range(0, 7) == 0);
      d = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 9));
      tick("random", r, e, v, d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
